// File: rtl/io_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// io_bus_pkg
// Shared types and constants for the uP register-bus slave sequencer.
//   ctrl_state_t : sequencer state encoding
//   RW_READ      : value of the bus RW bit that requests a read
//   TIMEOUT_TAG  : upper half of the word returned on a read timeout
//   STATUS_ADDR  : address of the optional controller status register
// ---------------------------------------------------------------------------
package io_bus_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DECODE    = 3'd1,
      READ_WAIT = 3'd2,
      ACK       = 3'd3,
      RELEASE   = 3'd4
   } ctrl_state_t;

   localparam logic        RW_READ     = 1'b1;
   localparam logic [15:0] TIMEOUT_TAG = 16'hDEAD;
   localparam logic [7:0]  STATUS_ADDR = 8'hFF;

   // Word handed back to the uP when the addressed unit never answers.
   function automatic logic [31:0] timeout_word(input logic [4:0] unit);
      return {TIMEOUT_TAG, 11'd0, unit};
   endfunction

endpackage

// File: rtl/io_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// IO_bus
// uP register-bus pins.
//   data_from_uP[31:0], reg_address[7:0], RW, handshake_1 : driven by the uP
//   data_to_uP[31:0], handshake_2                           : driven by slave
// Modports: master (uP side), slave (io_bus_ctrl side).
// ---------------------------------------------------------------------------
interface IO_bus;

   logic [31:0] data_from_uP;
   logic [7:0]  reg_address;
   logic        RW;
   logic        handshake_1;
   logic [31:0] data_to_uP;
   logic        handshake_2;

   modport master (
      output data_from_uP, reg_address, RW, handshake_1,
      input  data_to_uP, handshake_2
   );

   modport slave (
      input  data_from_uP, reg_address, RW, handshake_1,
      output data_to_uP, handshake_2
   );

endinterface

// File: rtl/io_bus_ctrl_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous level inputs.
//   clk   : destination clock
//   rst_b : asynchronous active-low reset, output resets to 0
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// ---------------------------------------------------------------------------
// io_bus_ctrl
// Slave-side sequencer for the uP register bus. Synchronises handshake_1,
// splits reg_address into unit[7:3] / reg[2:0], fires one-cycle read/write
// strobes to the addressed unit and runs the four-phase handshake back.
//
// Ports
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   bus           : IO_bus.slave uP pins
//   unit_wr_en    : one-hot write strobe (one cycle, during DECODE)
//   unit_rd_en    : one-hot read strobe (one cycle, during DECODE)
//   unit_reg      : local register index of the latched address
//   unit_wdata    : latched write data
//   unit_rdata    : per-unit read data, unit i at [32*i +: 32]
//   unit_rd_valid : per-unit read data valid
//   busy          : sequencer not in IDLE
//   error         : sticky fault flag
//
// Build option: define BUS_STATUS_REG_EN to make address 8'hFF an internal
// read-only status register {error, 7'b0, fault_count, last_fault_addr, 8'h00}
// whose read clears error and fault_count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for synchronised handshake_1, latches the request
// DECODE    | strobe fires here; invalid address faults straight to ACK
// READ_WAIT | waiting for the selected unit's rd_valid, or timeout
// ACK       | handshake_2 high, waiting for handshake_1 to drop
// RELEASE   | handshake_2 low for one cycle before returning to IDLE
// ---------------------------------------------------------------------------
module io_bus_ctrl
   import io_bus_pkg::*;
#(
   parameter int NUM_UNITS      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   IO_bus.slave                    bus,
   output logic [NUM_UNITS-1:0]    unit_wr_en,
   output logic [NUM_UNITS-1:0]    unit_rd_en,
   output logic [2:0]              unit_reg,
   output logic [31:0]             unit_wdata,
   input  logic [NUM_UNITS*32-1:0] unit_rdata,
   input  logic [NUM_UNITS-1:0]    unit_rd_valid,
   output logic                    busy,
   output logic                    error
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   ctrl_state_t          state;
   logic                 hs1_s;
   logic [7:0]           addr_q;
   logic                 rw_q;
   logic [31:0]          wdata_q;
   logic [31:0]          data_q;
   logic                 err_q;
   logic [CNT_W-1:0]     cnt;

   logic [4:0]           unit_idx;
   logic                 addr_ok;
   logic [NUM_UNITS-1:0] onehot;
   logic [31:0]          sel_rdata;
   logic                 sel_valid;
   logic                 decode_go;
   logic                 timeout_hit;
   logic                 is_status;
   logic                 status_rd;
   logic [31:0]          status_word;

   sync_2ff #(.WIDTH(1)) u_sync_hs1 (
      .clk   (clk),
      .rst_b (reset),
      .d     (bus.handshake_1),
      .q     (hs1_s)
   );

   assign unit_idx = addr_q[7:3];
   assign addr_ok  = (int'(unit_idx) < NUM_UNITS);

   // Only the latched unit's data/valid are looked at; every other valid is
   // ignored.
   always_comb begin
      onehot    = '0;
      sel_rdata = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (int'(unit_idx) == i) begin
            onehot[i] = 1'b1;
            sel_rdata = unit_rdata[i*32 +: 32];
            sel_valid = unit_rd_valid[i];
         end
      end
   end

   assign decode_go   = (state == DECODE) && addr_ok && !is_status;
   assign unit_wr_en  = (decode_go && rw_q != RW_READ) ? onehot : '0;
   assign unit_rd_en  = (decode_go && rw_q == RW_READ) ? onehot : '0;
   assign timeout_hit = (state == READ_WAIT) && !sel_valid && (cnt == '0);

`ifdef BUS_STATUS_REG_EN
   logic       fault_evt;
   logic [7:0] fault_count;
   logic [7:0] last_fault_addr;

   assign is_status   = (addr_q == STATUS_ADDR);
   assign status_rd   = (state == DECODE) && is_status && (rw_q == RW_READ);
   assign fault_evt   = ((state == DECODE) && !is_status && !addr_ok) || timeout_hit;
   assign status_word = {err_q, 7'd0, fault_count, last_fault_addr, 8'h00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_count     <= '0;
         last_fault_addr <= '0;
      end else if (status_rd) begin
         fault_count <= '0;
      end else if (fault_evt) begin
         if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
         last_fault_addr <= addr_q;
      end
   end
`else
   assign is_status   = 1'b0;
   assign status_rd   = 1'b0;
   assign status_word = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hs1_s) begin
                  addr_q  <= bus.reg_address;
                  rw_q    <= bus.RW;
                  wdata_q <= bus.data_from_uP;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               if (is_status) begin
                  // status writes are silently acknowledged
                  if (status_rd) begin
                     data_q <= status_word;
                     err_q  <= 1'b0;
                  end
                  state <= ACK;
               end else if (!addr_ok) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
                  state  <= ACK;
               end else if (rw_q == RW_READ) begin
                  cnt   <= CNT_W'(TIMEOUT_CYCLES);
                  state <= READ_WAIT;
               end else begin
                  state <= ACK;
               end
            end
            READ_WAIT: begin
               // valid wins over a timeout landing on the same cycle
               if (sel_valid) begin
                  data_q <= sel_rdata;
                  state  <= ACK;
               end else if (timeout_hit) begin
                  data_q <= timeout_word(unit_idx);
                  err_q  <= 1'b1;
                  state  <= ACK;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ACK: begin
               if (!hs1_s) state <= RELEASE;
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_to_uP  = data_q;
   assign bus.handshake_2 = (state == ACK);
   assign unit_reg        = addr_q[2:0];
   assign unit_wdata      = wdata_q;
   assign busy            = (state != IDLE);
   assign error           = err_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_bus_ctrl
// Self-checking bench for io_bus_ctrl (NUM_UNITS = 4, TIMEOUT_CYCLES = 8).
// Edge k counts rising edges from the first one after handshake_1 rises
// (k = 0); outputs are sampled on the falling edge after edge k. A spec
// "cycle N" event is therefore observed at k = N - 1.
// ---------------------------------------------------------------------------
module tb_io_bus_ctrl;

   localparam int NU = 4;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NU-1:0]     wr_en, rd_en;
   logic [2:0]        ureg;
   logic [31:0]       wdata;
   logic [NU*32-1:0]  rdata;
   logic [NU-1:0]     rvalid;
   logic              busy, error;

   IO_bus bus_if ();

   io_bus_ctrl #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus_if),
      .unit_wr_en    (wr_en),
      .unit_rd_en    (rd_en),
      .unit_reg      (ureg),
      .unit_wdata    (wdata),
      .unit_rdata    (rdata),
      .unit_rd_valid (rvalid),
      .busy          (busy),
      .error         (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_data;
   logic        m_err;
   logic [7:0]  m_fcnt;
   logic [7:0]  m_last;

   task automatic model_reset();
      m_data = '0;
      m_err  = 1'b0;
      m_fcnt = '0;
      m_last = '0;
   endtask

   // One complete uP transaction. d = cycles after the read strobe at which
   // the unit raises valid (0 = never). early = drop handshake_1 right away.
   task automatic do_txn(input logic [7:0] addr, input logic rw, input logic [31:0] wd,
                         input int d, input logic [31:0] rd, input bit early,
                         input string tag, output logic [31:0] got);
      int            unit;
      bit            is_stat;
      bit            ok;
      logic [NU-1:0] e_wr, e_rd;
      int            e_rise;
      logic [31:0]   e_data;
      logic          e_err;
      int            k, st_k, st_n, rise_k, fall_k, hi_n, unstable;
      logic [NU-1:0] st_wr, st_rd;
      logic [31:0]   o_data, o_wd;
      logic          o_err;
      logic [2:0]    o_reg;

      unit    = int'(addr[7:3]);
      is_stat = 1'b0;
`ifdef BUS_STATUS_REG_EN
      is_stat = (addr == 8'hFF);
`endif
      ok     = (unit < NU) && !is_stat;
      e_wr   = '0;
      e_rd   = '0;
      if (ok && !rw) e_wr[unit] = 1'b1;
      if (ok && rw)  e_rd[unit] = 1'b1;
      e_data = m_data;
      e_err  = m_err;
      e_rise = 3;
      if (is_stat) begin
         if (rw) begin
            e_data = {m_err, 7'd0, m_fcnt, m_last, 8'h00};
            e_err  = 1'b0;
            m_fcnt = '0;
         end
      end else if (!ok) begin
         e_data = '0;
         e_err  = 1'b1;
         if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
         m_last = addr;
      end else if (rw) begin
         if (d >= 1 && d <= TO + 1) begin
            e_rise = 3 + d;
            e_data = rd;
         end else begin
            e_rise = 3 + TO + 1;
            e_data = 32'hDEAD_0000 | 32'(unit);
            e_err  = 1'b1;
            if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
            m_last = addr;
         end
      end

      @(negedge clk);
      bus_if.reg_address  = addr;
      bus_if.RW           = rw;
      bus_if.data_from_uP = wd;
      bus_if.handshake_1  = 1'b1;
      for (int i = 0; i < NU; i++) rdata[i*32 +: 32] = $urandom;
      rvalid = NU'($urandom);
      if (ok) rvalid[unit] = 1'b0;

      k = -1; st_k = -1; st_n = 0; rise_k = -1; fall_k = -1; hi_n = 0; unstable = 0;
      st_wr = '0; st_rd = '0; o_data = '0; o_wd = '0; o_err = 1'b0; o_reg = '0;
      while (k < 80) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (early && k == 0) bus_if.handshake_1 = 1'b0;
         if (ok && rw && d >= 1 && k == 2 + d) begin
            rvalid[unit]         = 1'b1;
            rdata[unit*32 +: 32] = rd;
         end
         if (wr_en != '0 || rd_en != '0) begin
            if (st_n == 0) begin
               st_k  = k;
               st_wr = wr_en;
               st_rd = rd_en;
            end
            st_n++;
         end
         if (bus_if.handshake_2) begin
            hi_n++;
            if (rise_k < 0) begin
               rise_k = k;
               o_data = bus_if.data_to_uP;
               o_err  = error;
               o_reg  = ureg;
               o_wd   = wdata;
               if (!early) bus_if.handshake_1 = 1'b0;
            end else if (bus_if.data_to_uP !== o_data) begin
               unstable++;
            end
         end else if (rise_k >= 0 && fall_k < 0) begin
            fall_k = k;
         end
         if (fall_k >= 0 && !busy) break;
      end
      rvalid = '0;
      bus_if.handshake_1 = 1'b0;
      got = o_data;

      total++;
      if (fall_k < 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s complete: rise=%0d fall=%0d busy=%b, required handshake done and idle", tag, rise_k, fall_k, busy);
      end
      total++;
      if (st_wr !== e_wr || st_rd !== e_rd) begin
         bad++;
         $display("FAIL %s strobe: wr=%b rd=%b, required wr=%b rd=%b", tag, st_wr, st_rd, e_wr, e_rd);
      end
      if (e_wr != '0 || e_rd != '0) begin
         total++;
         if (st_k !== 2 || st_n !== 1) begin
            bad++;
            $display("FAIL %s strobe_timing: k=%0d width=%0d, required k=2 width=1", tag, st_k, st_n);
         end
      end
      total++;
      if (rise_k !== e_rise) begin
         bad++;
         $display("FAIL %s hs2_rise: k=%0d, required k=%0d", tag, rise_k, e_rise);
      end
      total++;
      if (o_data !== e_data || unstable != 0) begin
         bad++;
         $display("FAIL %s data_to_uP: %h (unstable=%0d), required %h", tag, o_data, unstable, e_data);
      end
      total++;
      if (o_err !== e_err) begin
         bad++;
         $display("FAIL %s error: %b, required %b", tag, o_err, e_err);
      end
      total++;
      if (o_reg !== addr[2:0]) begin
         bad++;
         $display("FAIL %s unit_reg: %0d, required %0d", tag, o_reg, addr[2:0]);
      end
      if (!rw) begin
         total++;
         if (o_wd !== wd) begin
            bad++;
            $display("FAIL %s unit_wdata: %h, required %h", tag, o_wd, wd);
         end
      end
      total++;
      if (early ? (hi_n !== 1 || fall_k !== rise_k + 1) : (hi_n !== 3 || fall_k !== rise_k + 3)) begin
         bad++;
         $display("FAIL %s hs2_fall: high=%0d fall=%0d rise=%0d, required high=%0d", tag, hi_n, fall_k, rise_k, early ? 1 : 3);
      end
      m_data = e_data;
      m_err  = e_err;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      bus_if.handshake_1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus_if.handshake_1 = 1'b0; bus_if.RW = 1'b0;
      bus_if.reg_address = '0;   bus_if.data_from_uP = '0;
      rdata = '0; rvalid = '0;
      model_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({wr_en, rd_en, ureg, wdata, busy, error} !== '0) begin
         bad++;
         $display("FAIL reset_unit_outputs: wr=%b rd=%b reg=%0d wdata=%h busy=%b err=%b, required all 0", wr_en, rd_en, ureg, wdata, busy, error);
      end
      total++;
      if (bus_if.data_to_uP !== 32'd0 || bus_if.handshake_2 !== 1'b0) begin
         bad++;
         $display("FAIL reset_bus_outputs: data=%h hs2=%b, required 0 0", bus_if.data_to_uP, bus_if.handshake_2);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      logic [31:0] g;
      do_txn(8'h0A, 1'b0, 32'h1234_5678, 0, 32'h0, 1'b0, "write", g);
   endtask

   task automatic test_read();
      logic [31:0] g;
      do_txn(8'h13, 1'b1, 32'h0, 3, 32'hCAFE_0001, 1'b0, "read", g);
      total++;
      if (g !== 32'hCAFE_0001) begin
         bad++;
         $display("FAIL read_literal: %h, required cafe0001", g);
      end
   endtask

   task automatic test_invalid();
      logic [31:0] g;
      do_txn(8'h28, 1'b1, 32'h0, 1, 32'h5555_AAAA, 1'b0, "invalid_rd", g);
      do_txn(8'h31, 1'b0, 32'hFFFF_0000, 0, 32'h0, 1'b0, "invalid_wr", g);
      do_txn(8'hFF, 1'b1, 32'h0, 1, 32'h0, 1'b0, "addr_ff_rd", g);
   endtask

   task automatic test_timeout();
      logic [31:0] g;
      apply_reset();
      do_txn(8'h08, 1'b1, 32'h0, 0, 32'h0, 1'b0, "timeout", g);
      total++;
      if (g !== 32'hDEAD_0001 || error !== 1'b1) begin
         bad++;
         $display("FAIL timeout_literal: %h err=%b, required dead0001 1", g, error);
      end
      do_txn(8'h1C, 1'b1, 32'h0, TO + 1, 32'h0BAD_F00D, 1'b0, "valid_at_limit", g);
      do_txn(8'h04, 1'b1, 32'h0, TO + 2, 32'h0BAD_F00D, 1'b0, "valid_too_late", g);
   endtask

   task automatic test_early_drop();
      logic [31:0] g;
      do_txn(8'h19, 1'b0, 32'hA5A5_5A5A, 0, 32'h0, 1'b1, "early_wr", g);
      do_txn(8'h02, 1'b1, 32'h0, 4, 32'h7777_1234, 1'b1, "early_rd", g);
   endtask

   task automatic test_random();
      logic [31:0] g;
      logic [7:0]  a;
      for (int n = 0; n < 30; n++) begin
         a = {5'($urandom_range(0, 5)), 3'($urandom)};
         do_txn(a, 1'($urandom), $urandom, $urandom_range(1, 12), $urandom,
                ($urandom_range(0, 4) == 0), "random", g);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] g;
      int          k;
      bit          strobe_seen;
      @(negedge clk);
      bus_if.reg_address = 8'h0B;
      bus_if.RW          = 1'b1;
      bus_if.handshake_1 = 1'b1;
      k = -1;
      strobe_seen = 1'b0;
      while (k < 5) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      reset = 1'b0;
      bus_if.handshake_1 = 1'b0;
      #1;
      total++;
      if ({wr_en, rd_en, ureg, wdata, busy, error, bus_if.handshake_2} !== '0 || bus_if.data_to_uP !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid_read: busy=%b hs2=%b data=%h reg=%0d err=%b, required all 0", busy, bus_if.handshake_2, bus_if.data_to_uP, ureg, error);
      end
      repeat (2) begin
         @(negedge clk);
         if (wr_en != '0 || rd_en != '0) strobe_seen = 1'b1;
      end
      reset = 1'b1;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         if (wr_en != '0 || rd_en != '0) strobe_seen = 1'b1;
      end
      total++;
      if (strobe_seen || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_quiet: strobe=%b busy=%b, required 0 0", strobe_seen, busy);
      end
      do_txn(8'h1D, 1'b0, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, "write_after_reset", g);
   endtask

`ifdef BUS_STATUS_REG_EN
   task automatic test_status();
      logic [31:0] g;
      apply_reset();
      do_txn(8'h28, 1'b1, 32'h0, 0, 32'h0, 1'b0, "fault1", g);
      do_txn(8'h08, 1'b1, 32'h0, 0, 32'h0, 1'b0, "fault2", g);
      do_txn(8'hFF, 1'b0, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, "status_wr", g);
      do_txn(8'hFF, 1'b1, 32'h0, 0, 32'h0, 1'b0, "status_rd1", g);
      total++;
      if (g !== 32'h8002_0800) begin
         bad++;
         $display("FAIL status_rd1_literal: %h, required 80020800", g);
      end
      do_txn(8'hFF, 1'b1, 32'h0, 0, 32'h0, 1'b0, "status_rd2", g);
      total++;
      if (g !== 32'h0000_0800) begin
         bad++;
         $display("FAIL status_rd2_literal: %h, required 00000800", g);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_invalid();
      test_timeout();
      test_early_drop();
      test_random();
      test_reset_mid_read();
`ifdef BUS_STATUS_REG_EN
      test_status();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
